// File: rtl/pid_wb_master.sv
// Wishbone master that loads PID gains/setpoint into a controller, then for each
// accepted process-variable sample writes it out and reads back the control output.
module pid_wb_master #(
   parameter int wb_nb     = 16,
   parameter int adr_wb_nb = 16,
   parameter int kp_adr    = 0,
   parameter int ki_adr    = 1,
   parameter int kd_adr    = 2,
   parameter int sp_adr    = 3,
   parameter int pv_adr    = 4,
   parameter int un_adr    = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cfg_start,
   input  logic [wb_nb-1:0]     i_kp,
   input  logic [wb_nb-1:0]     i_ki,
   input  logic [wb_nb-1:0]     i_kd,
   input  logic [wb_nb-1:0]     i_sp,
   input  logic                 i_pv_valid,
   input  logic [wb_nb-1:0]     i_pv,
   output logic                 o_pv_ready,
   output logic                 o_wb_cyc,
   output logic                 o_wb_stb,
   output logic                 o_wb_we,
   output logic [adr_wb_nb-1:0] o_wb_adr,
   output logic [wb_nb-1:0]     o_wb_data,
   input  logic                 i_wb_ack,
   input  logic [wb_nb-1:0]     i_wb_data,
   output logic [wb_nb-1:0]     o_un,
   output logic                 o_un_valid,
   output logic                 o_busy,
   output logic                 o_cfg_done,
   output logic                 o_timeout
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, CFG_KP, CFG_KI, CFG_KD, CFG_SP, RUN, PV_WR, UN_RD
   } state_t;

   state_t               r_state;
   logic [wb_nb-1:0]     r_kp, r_ki, r_kd, r_sp, r_pv;
   logic                 r_cyc, r_stb, r_we;
   logic [adr_wb_nb-1:0] r_adr;
   logic [wb_nb-1:0]     r_data;
   logic [wb_nb-1:0]     r_un;
   logic                 r_un_valid, r_cfg_done, r_timeout;
   logic [CNT_W-1:0]     r_cnt;

   logic [adr_wb_nb-1:0] w_adr;
   logic [wb_nb-1:0]     w_data;
   logic                 w_we;
   state_t               w_next;

   // Address, data and successor of the transaction owned by each bus state.
   always_comb begin
      w_adr  = '0;
      w_data = '0;
      w_we   = 1'b1;
      w_next = IDLE;
      case (r_state)
         CFG_KP: begin w_adr = adr_wb_nb'(kp_adr); w_data = r_kp; w_next = CFG_KI; end
         CFG_KI: begin w_adr = adr_wb_nb'(ki_adr); w_data = r_ki; w_next = CFG_KD; end
         CFG_KD: begin w_adr = adr_wb_nb'(kd_adr); w_data = r_kd; w_next = CFG_SP; end
         CFG_SP: begin w_adr = adr_wb_nb'(sp_adr); w_data = r_sp; w_next = RUN;    end
         PV_WR:  begin w_adr = adr_wb_nb'(pv_adr); w_data = r_pv; w_next = UN_RD;  end
         UN_RD:  begin w_adr = adr_wb_nb'(un_adr); w_we = 1'b0;   w_next = RUN;    end
         default: w_we = 1'b0;
      endcase
   end

   // Bus states enter with cyc low and raise it one cycle later, which gives the
   // mandatory idle cycle between back-to-back transactions.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_kp       <= '0;
         r_ki       <= '0;
         r_kd       <= '0;
         r_sp       <= '0;
         r_pv       <= '0;
         r_cyc      <= 1'b0;
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_adr      <= '0;
         r_data     <= '0;
         r_un       <= '0;
         r_un_valid <= 1'b0;
         r_cfg_done <= 1'b0;
         r_timeout  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_un_valid <= 1'b0;
         case (r_state)
            IDLE, RUN: begin
               if (i_cfg_start) begin
                  r_kp       <= i_kp;
                  r_ki       <= i_ki;
                  r_kd       <= i_kd;
                  r_sp       <= i_sp;
                  r_cfg_done <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_state    <= CFG_KP;
               end else if (r_state == RUN && i_pv_valid) begin
                  r_pv    <= i_pv;
                  r_state <= PV_WR;
               end
            end
            default: begin
               if (!r_cyc) begin
                  r_cyc  <= 1'b1;
                  r_stb  <= 1'b1;
                  r_cnt  <= '0;
                  r_adr  <= w_adr;
                  r_data <= w_data;
                  r_we   <= w_we;
               end else if (i_wb_ack) begin
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_state <= w_next;
                  if (r_state == CFG_SP) r_cfg_done <= 1'b1;
                  if (r_state == UN_RD) begin
                     r_un       <= i_wb_data;
                     r_un_valid <= 1'b1;
                  end
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_cyc      <= 1'b0;
                  r_stb      <= 1'b0;
                  r_timeout  <= 1'b1;
                  r_cfg_done <= 1'b0;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign o_wb_cyc   = r_cyc;
   assign o_wb_stb   = r_stb;
   assign o_wb_we    = r_we;
   assign o_wb_adr   = r_adr;
   assign o_wb_data  = r_data;
   assign o_un       = r_un;
   assign o_un_valid = r_un_valid;
   assign o_cfg_done = r_cfg_done;
   assign o_timeout  = r_timeout;
   assign o_busy     = (r_state != IDLE) && (r_state != RUN);
   // Configuration has priority over a coinciding sample.
   assign o_pv_ready = (r_state == RUN) && !i_cfg_start;

endmodule

// File: tb/tb_pid_wb_master.sv
// Self-checking bench for pid_wb_master: behavioural Wishbone slave with wait
// states, a transaction log compared against expected bus traffic, and corner cases.
module tb_pid_wb_master;

   localparam logic [15:0] KP_ADR = 16'd0;
   localparam logic [15:0] KI_ADR = 16'd1;
   localparam logic [15:0] KD_ADR = 16'd2;
   localparam logic [15:0] SP_ADR = 16'd3;
   localparam logic [15:0] PV_ADR = 16'd4;
   localparam logic [15:0] UN_ADR = 16'd8;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_cfg_start = 1'b0;
   logic [15:0] i_kp = '0, i_ki = '0, i_kd = '0, i_sp = '0;
   logic        i_pv_valid = 1'b0;
   logic [15:0] i_pv = '0;
   logic        o_pv_ready;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [15:0] o_wb_adr, o_wb_data;
   logic        i_wb_ack = 1'b0;
   logic [15:0] i_wb_data = '0;
   logic [15:0] o_un;
   logic        o_un_valid, o_busy, o_cfg_done, o_timeout;

   pid_wb_master dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_start(i_cfg_start),
      .i_kp(i_kp), .i_ki(i_ki), .i_kd(i_kd), .i_sp(i_sp),
      .i_pv_valid(i_pv_valid), .i_pv(i_pv), .o_pv_ready(o_pv_ready),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
      .o_un(o_un), .o_un_valid(o_un_valid), .o_busy(o_busy),
      .o_cfg_done(o_cfg_done), .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   typedef logic [32:0] txn_t;  // {we, adr, data}
   txn_t logQ[$];
   txn_t expQ[$];

   int checks = 0;
   int failures = 0;
   int protoErrors = 0;
   int slaveWaits = 0;
   bit slaveNoAck = 1'b0;
   logic [15:0] slaveRd = '0;
   int stbCount = 0;
   int stbRises = 0;
   logic [15:0] lastUn = '0;

   bit stbPrev = 1'b0, ackPrev = 1'b0;
   logic [32:0] prevBus = '0;

   // Slave acts on the falling edge so its ack is settled at the next rising edge.
   always @(negedge i_clk) begin
      if (o_wb_cyc && o_wb_stb) begin
         if (ackPrev) protoErrors++;
         if (stbPrev && !ackPrev && prevBus != {o_wb_we, o_wb_adr, o_wb_data}) protoErrors++;
         if (!stbPrev || ackPrev) begin
            stbCount = 1;
            stbRises++;
         end else begin
            stbCount++;
         end
         if (!slaveNoAck && stbCount - 1 >= slaveWaits) begin
            i_wb_ack = 1'b1;
            i_wb_data = o_wb_we ? 16'h0 : slaveRd;
            logQ.push_back({o_wb_we, o_wb_adr, o_wb_data});
         end else begin
            i_wb_ack = 1'b0;
            i_wb_data = '0;
         end
      end else begin
         i_wb_ack = 1'b0;
         i_wb_data = '0;
      end
      stbPrev = o_wb_cyc && o_wb_stb;
      ackPrev = i_wb_ack;
      prevBus = {o_wb_we, o_wb_adr, o_wb_data};
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic compareLog(input string tag);
      int n;
      checkOutput({tag, " txn count"}, 64'(logQ.size()), 64'(expQ.size()));
      n = (logQ.size() < expQ.size()) ? logQ.size() : expQ.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s txn%0d", tag, i), 64'(logQ[i]), 64'(expQ[i]));
   endtask

   // Reference: a configuration writes Kp, Ki, Kd, SP to their addresses in that order.
   task automatic modelConfig(input logic [15:0] kp, ki, kd, sp);
      expQ.delete();
      expQ.push_back({1'b1, KP_ADR, kp});
      expQ.push_back({1'b1, KI_ADR, ki});
      expQ.push_back({1'b1, KD_ADR, kd});
      expQ.push_back({1'b1, SP_ADR, sp});
   endtask

   task automatic pulseConfig(input logic [15:0] kp, ki, kd, sp);
      @(posedge i_clk); #1;
      i_kp = kp; i_ki = ki; i_kd = kd; i_sp = sp;
      i_cfg_start = 1'b1;
      @(posedge i_clk); #1;
      i_cfg_start = 1'b0;
   endtask

   task automatic waitConfigDone(input string tag);
      bit done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge i_clk);
         if (o_cfg_done && !o_busy) done = 1'b1;
      end
      checkOutput({tag, " cfg_done"}, 64'(done), 64'd1);
   endtask

   task automatic applyConfig(input string tag, input logic [15:0] kp, ki, kd, sp);
      logQ.delete();
      modelConfig(kp, ki, kd, sp);
      pulseConfig(kp, ki, kd, sp);
      waitConfigDone(tag);
      checkOutput({tag, " busy"}, 64'(o_busy), 64'd0);
      compareLog(tag);
   endtask

   task automatic applySample(input string tag, input logic [15:0] pv, input logic [15:0] rd);
      bit seen = 1'b0;
      logQ.delete();
      expQ.delete();
      expQ.push_back({1'b1, PV_ADR, pv});
      expQ.push_back({1'b0, UN_ADR, 16'h0});
      slaveRd = rd;
      @(negedge i_clk);
      checkOutput({tag, " pv_ready"}, 64'(o_pv_ready), 64'd1);
      checkOutput({tag, " un held"}, 64'(o_un), 64'(lastUn));
      @(posedge i_clk); #1;
      i_pv = pv;
      i_pv_valid = 1'b1;
      @(posedge i_clk); #1;
      i_pv_valid = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge i_clk);
         if (o_un_valid) seen = 1'b1;
      end
      checkOutput({tag, " un_valid seen"}, 64'(seen), 64'd1);
      checkOutput({tag, " un"}, 64'(o_un), 64'(rd));
      @(negedge i_clk);
      checkOutput({tag, " un_valid one cycle"}, 64'(o_un_valid), 64'd0);
      compareLog(tag);
      lastUn = rd;
   endtask

   typedef struct {
      logic [15:0] kp, ki, kd, sp, pv, rdVal;
      int          waits;
      logic [15:0] expUn;
   } vec_t;
   vec_t vecs[4];

   task automatic applyStimulus(input int idx, input vec_t v);
      slaveWaits = v.waits;
      applyConfig($sformatf("vec%0d cfg", idx), v.kp, v.ki, v.kd, v.sp);
      applySample($sformatf("vec%0d pv", idx), v.pv, v.rdVal);
      checkOutput($sformatf("vec%0d expUn", idx), 64'(o_un), 64'(v.expUn));
   endtask

   initial begin
      bit ok;
      int rises;
      vecs[0] = '{16'd3, 16'd5, 16'd7, 16'd100, 16'd40, 16'h1234, 0, 16'h1234};
      vecs[1] = '{16'd3, 16'd5, 16'd7, 16'd100, 16'd40, 16'h1234, 3, 16'h1234};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF};
      vecs[3] = '{16'h0000, 16'hA5A5, 16'h5A5A, 16'h0001, 16'h0000, 16'h0000, 2, 16'h0000};

      #2 i_rst_n = 1'b0;
      #1;
      checkOutput("reset outputs",
                  {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_un, o_un_valid,
                   o_pv_ready, o_busy, o_cfg_done, o_timeout}, 64'd0);
      repeat (2) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      repeat (5) @(negedge i_clk);
      checkOutput("no activity before start", 64'(stbRises), 64'd0);

      foreach (vecs[i]) applyStimulus(i, vecs[i]);

      // Coinciding configuration request and sample: configuration wins.
      slaveWaits = 0;
      logQ.delete();
      modelConfig(16'h0011, 16'h0022, 16'h0033, 16'h0044);
      @(negedge i_clk);
      checkOutput("coinc in RUN", 64'(o_pv_ready), 64'd1);
      @(posedge i_clk); #1;
      i_kp = 16'h0011; i_ki = 16'h0022; i_kd = 16'h0033; i_sp = 16'h0044;
      i_pv = 16'h5555;
      i_cfg_start = 1'b1;
      i_pv_valid = 1'b1;
      @(negedge i_clk);
      checkOutput("coinc pv_ready", 64'(o_pv_ready), 64'd0);
      @(posedge i_clk); #1;
      i_cfg_start = 1'b0;
      i_pv_valid = 1'b0;
      waitConfigDone("coinc");
      compareLog("coinc");

      // Randomised mix of configurations and samples.
      for (int it = 0; it < 30; it++) begin
         slaveWaits = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0)
            applyConfig($sformatf("rnd%0d cfg", it), 16'($urandom), 16'($urandom),
                        16'($urandom), 16'($urandom));
         else
            applySample($sformatf("rnd%0d pv", it), 16'($urandom), 16'($urandom));
      end

      // Slave never acknowledges.
      slaveNoAck = 1'b1;
      logQ.delete();
      pulseConfig(16'd1, 16'd2, 16'd3, 16'd4);
      ok = 1'b0;
      for (int c = 0; c < 2000 && !ok; c++) begin
         @(negedge i_clk);
         if (o_timeout) ok = 1'b1;
      end
      checkOutput("timeout set", 64'(ok), 64'd1);
      checkOutput("timeout stb cycles", 64'(stbCount), 64'd255);
      checkOutput("timeout cyc", 64'(o_wb_cyc), 64'd0);
      checkOutput("timeout cfg_done", 64'(o_cfg_done), 64'd0);
      checkOutput("timeout idle", {o_busy, o_pv_ready}, 64'd0);
      repeat (3) @(negedge i_clk);
      checkOutput("timeout sticky no resume", {o_timeout, o_wb_cyc}, 64'b10);
      slaveNoAck = 1'b0;
      slaveWaits = 1;
      modelConfig(16'd9, 16'd8, 16'd7, 16'd6);
      pulseConfig(16'd9, 16'd8, 16'd7, 16'd6);
      @(negedge i_clk);
      checkOutput("timeout cleared", 64'(o_timeout), 64'd0);
      waitConfigDone("after timeout");
      compareLog("after timeout");

      // Reset during the Ki write.
      slaveWaits = 3;
      pulseConfig(16'd21, 16'd22, 16'd23, 16'd24);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge i_clk);
         if (o_wb_stb && o_wb_adr == KI_ADR) ok = 1'b1;
      end
      checkOutput("reached CFG_KI", 64'(ok), 64'd1);
      #2 i_rst_n = 1'b0;
      #1;
      checkOutput("mid-txn reset outputs",
                  {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_un, o_un_valid,
                   o_pv_ready, o_busy, o_cfg_done, o_timeout}, 64'd0);
      repeat (2) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      rises = stbRises;
      repeat (20) @(negedge i_clk);
      checkOutput("no resume after reset", 64'(stbRises - rises), 64'd0);
      checkOutput("post-reset status", {o_busy, o_cfg_done, o_pv_ready}, 64'd0);
      lastUn = '0;
      slaveWaits = 0;
      applyConfig("post reset", 16'd31, 16'd32, 16'd33, 16'd34);

      checkOutput("bus protocol", 64'(protoErrors), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pid_wb_master.md
PID_WB_MASTER -- requirements
Module: pid_wb_master

Interface
REQ-001 SHALL have parameter wb_nb, default 16: Wishbone data width.
REQ-002 SHALL have parameter adr_wb_nb, default 16: Wishbone address width.
REQ-003 SHALL have parameters kp_adr=0, ki_adr=1, kd_adr=2, sp_adr=3, pv_adr=4, un_adr=8: target register addresses.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles waiting for ack.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 i_clk  in  1  rising-edge clock.
REQ-007 i_rst_n  in  1  asynchronous active-low reset.
REQ-008 i_cfg_start  in  1  one-cycle pulse requesting a configuration sequence.
REQ-009 i_kp, i_ki, i_kd, i_sp  in  wb_nb each  gain and setpoint values.
REQ-010 i_pv_valid  in  1 / i_pv  in  wb_nb  process-variable sample, valid/ready handshake.
REQ-011 o_pv_ready  out  1  sample accepted when high together with i_pv_valid.
REQ-012 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
REQ-013 o_wb_adr  out  adr_wb_nb / o_wb_data  out  wb_nb  Wishbone address and write data.
REQ-014 i_wb_ack  in  1 / i_wb_data  in  wb_nb  slave acknowledge and read data.
REQ-015 o_un  out  wb_nb / o_un_valid  out  1  control output read back, with a one-cycle strobe.
REQ-016 o_busy, o_cfg_done, o_timeout  out  1 each  status flags.

Function
REQ-017 States SHALL be: IDLE, CFG_KP, CFG_KI, CFG_KD, CFG_SP, RUN, PV_WR, UN_RD.
REQ-018 On i_cfg_start in IDLE or RUN: capture i_kp/i_ki/i_kd/i_sp, clear o_cfg_done, go to CFG_KP; i_cfg_start is ignored in all other states.
REQ-019 Each CFG_x, PV_WR or UN_RD state SHALL issue one single Wishbone cycle: cyc=stb=1, adr and data driven from registers, held stable until ack.
REQ-020 Writes set we=1; UN_RD sets we=0 with adr=un_adr and drives o_wb_data to 0.
REQ-021 The cycle completes on the first clock edge with cyc&stb&i_wb_ack, including an ack in the first stb cycle; cyc/stb SHALL then be 0 for at least one cycle before the next transaction.
REQ-022 CFG_KP->CFG_KI->CFG_KD->CFG_SP advance on ack; the CFG_SP ack sets o_cfg_done=1 and enters RUN.
REQ-023 o_pv_ready SHALL be 1 only in RUN with no transaction in progress and i_cfg_start=0; when i_cfg_start and i_pv_valid coincide, configuration wins and the sample is not accepted.
REQ-024 On i_pv_valid&o_pv_ready: capture i_pv, write it to pv_adr (PV_WR), then read un_adr (UN_RD).
REQ-025 On the UN_RD ack: o_un<=i_wb_data, o_un_valid=1 for exactly the next cycle, return to RUN.
REQ-026 o_busy SHALL be 1 in every state except IDLE and RUN.
REQ-027 A cycle counter SHALL run while stb=1 with no ack and clear at the start of each transaction.
REQ-028 If the counter reaches TIMEOUT with no ack: drop cyc/stb the next cycle, set o_timeout (sticky), clear o_cfg_done, and go to IDLE.
REQ-029 o_timeout SHALL clear only on reset or on an accepted i_cfg_start.
REQ-030 i_wb_ack while cyc=0 SHALL be ignored.

Reset
REQ-031 While i_rst_n=0, asynchronously: state=IDLE; every output=0 (cyc, stb, we, adr, o_wb_data, o_un, o_un_valid, o_pv_ready, o_busy, o_cfg_done, o_timeout); counter=0.
REQ-032 Reset asserted mid-transaction SHALL drop cyc/stb immediately; no operation resumes after release.
REQ-033 The first transaction after release SHALL need a fresh i_cfg_start.

Verification
REQ-034 Zero-wait slave, i_kp=3, i_ki=5, i_kd=7, i_sp=100, pulse i_cfg_start -> writes (0,3),(1,5),(2,7),(3,100) in order, each separated by an idle cycle; o_cfg_done=1; o_busy=0.
REQ-035 After configuration, i_pv=40 with i_pv_valid, slave returns 0x1234 on read of adr 8 -> write (4,40), then read adr 8; o_un=0x1234 with o_un_valid high for exactly one cycle.
REQ-036 Slave inserts 3 wait states on each ack -> adr/data/we stay stable for all stb cycles; sequence and results match REQ-034/REQ-035.
REQ-037 Slave never acks, TIMEOUT=255 -> cyc drops after 255 stb cycles; o_timeout=1, o_cfg_done=0, state IDLE; a new i_cfg_start clears o_timeout.
REQ-038 i_cfg_start and i_pv_valid asserted in the same RUN cycle -> o_pv_ready=0, configuration runs, pv_adr is not written.
REQ-039 i_rst_n pulled low during CFG_KI stb -> cyc/stb/all outputs go 0 the same cycle; after release there is no bus activity until i_cfg_start.
